// File: rtl/johnson_decoder.sv
// Johnson-code decoder with sequence tracking, lock detection and error flagging.
// Define JOHNSON_DECODER_ERRCNT_EN to build the saturating err_count; otherwise err_count is tied to 0.
//
// state    | meaning
// UNLOCKED | no reference held; the next legal code becomes the reference
// ACQUIRE  | counting consecutive legal advances towards LOCK_CNT
// LOCKED   | tracking; any break in the sequence pulses seq_err
module johnson_decoder #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [WIDTH-1:0]              q_in,
  input  logic                          valid_in,
  output logic [$clog2(2*WIDTH)-1:0]    state_idx,
  output logic [2*WIDTH-1:0]            onehot,
  output logic                          code_valid,
  output logic                          locked,
  output logic                          seq_err,
  output logic [7:0]                    err_count
);

  localparam int N     = 2 * WIDTH;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        adv_cnt, adv_nxt;
  logic [IDX_W-1:0]  idx_nxt, dec_idx, succ_idx;
  logic [N-1:0]      onehot_nxt;
  logic              cv_nxt, hit, is_adv, err_pulse;

  function automatic logic [WIDTH-1:0] pat(input int k);
    logic [WIDTH-1:0] p;
    p = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (k <= WIDTH) p[b] = (b < k);
      else            p[b] = (b >= k - WIDTH);
    end
    return p;
  endfunction

  always_comb begin
    hit     = 1'b0;
    dec_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (q_in == pat(k)) begin
        hit     = 1'b1;
        dec_idx = IDX_W'(k);
      end
    end
  end

  // state_idx always holds the last legal code, so it doubles as the reference
  assign succ_idx = (state_idx == LAST_IDX) ? '0 : state_idx + 1'b1;
  assign is_adv   = hit && (dec_idx == succ_idx);

  always_comb begin
    state_nxt  = state;
    adv_nxt    = adv_cnt;
    idx_nxt    = state_idx;
    cv_nxt     = code_valid;
    onehot_nxt = onehot;
    err_pulse  = 1'b0;
    if (valid_in) begin
      if (!hit) begin
        cv_nxt     = 1'b0;
        onehot_nxt = '0;
        err_pulse  = 1'b1;
        state_nxt  = UNLOCKED;
        adv_nxt    = '0;
      end else begin
        cv_nxt     = 1'b1;
        idx_nxt    = dec_idx;
        onehot_nxt = {{(N-1){1'b0}}, 1'b1} << dec_idx;
        case (state)
          UNLOCKED: begin
            state_nxt = ACQUIRE;
            adv_nxt   = '0;
          end
          ACQUIRE: begin
            if (is_adv) begin
              adv_nxt = adv_cnt + 4'd1;
              if (adv_cnt + 4'd1 >= LOCK_TGT) state_nxt = LOCKED;
            end else begin
              adv_nxt = '0;
            end
          end
          LOCKED: begin
            if (!is_adv) begin
              err_pulse = 1'b1;
              state_nxt = ACQUIRE;
              adv_nxt   = '0;
            end
          end
          default: begin
            state_nxt = UNLOCKED;
            adv_nxt   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= UNLOCKED;
      adv_cnt    <= '0;
      state_idx  <= '0;
      onehot     <= '0;
      code_valid <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      adv_cnt    <= adv_nxt;
      state_idx  <= idx_nxt;
      onehot     <= onehot_nxt;
      code_valid <= cv_nxt;
      seq_err    <= err_pulse;
    end
  end

  assign locked = (state == LOCKED);

`ifdef JOHNSON_DECODER_ERRCNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             err_count <= '0;
    else if (err_pulse && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_johnson_decoder.sv
// Scoreboard bench for johnson_decoder: driver pushes model predictions, monitor pops and compares.
module tb_johnson_decoder;

  localparam int W  = 4;
  localparam int N  = 2 * W;
  localparam int LC = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] q_in = '0;
  logic       valid_in = 1'b0;
  logic [2:0] state_idx;
  logic [7:0] onehot;
  logic       code_valid, locked, seq_err;
  logic [7:0] err_count;

  johnson_decoder #(.WIDTH(W), .LOCK_CNT(LC)) dut (
    .clk(clk), .reset_n(reset_n), .q_in(q_in), .valid_in(valid_in),
    .state_idx(state_idx), .onehot(onehot), .code_valid(code_valid),
    .locked(locked), .seq_err(seq_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] oh;
    logic       cv;
    logic       lk;
    logic       se;
    logic [7:0] ec;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // reference model: mode 0=unlocked, 1=acquiring, 2=locked
  int m_mode, m_idx, m_cnt, m_err;
  bit m_cv;

  function automatic int jc(input int k);
    if (k <= W) return (1 << k) - 1;
    return (1 << W) - (1 << (k - W));
  endfunction

  function automatic int code_index(input int code);
    for (int k = 0; k < N; k++) if (jc(k) == code) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_cnt = 0; m_err = 0; m_cv = 0;
  endtask

  task automatic apply(input bit v, input logic [3:0] q);
    exp_t e;
    int k;
    bit se;
    @(negedge clk);
    valid_in = v;
    q_in = q;
    se = 0;
    if (v) begin
      k = code_index(int'(q));
      if (k < 0) begin
        m_cv = 0; m_mode = 0; m_cnt = 0; se = 1;
      end else begin
        bit adv;
        adv = (k == (m_idx + 1) % N);
        m_cv = 1;
        if (m_mode == 0) begin
          m_mode = 1; m_cnt = 0;
        end else if (m_mode == 1) begin
          if (adv) begin
            m_cnt++;
            if (m_cnt >= LC) m_mode = 2;
          end else m_cnt = 0;
        end else if (!adv) begin
          se = 1; m_mode = 1; m_cnt = 0;
        end
        m_idx = k;
      end
      if (se && m_err < 255) m_err++;
    end
    e.idx = 3'(m_idx);
    e.oh  = m_cv ? 8'(1 << m_idx) : 8'h00;
    e.cv  = m_cv;
    e.lk  = (m_mode == 2);
    e.se  = se;
`ifdef JOHNSON_DECODER_ERRCNT_EN
    e.ec  = 8'(m_err);
`else
    e.ec  = 8'h00;
`endif
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if ({state_idx, onehot, code_valid, locked, seq_err, err_count} !==
          {e.idx, e.oh, e.cv, e.lk, e.se, e.ec}) begin
        miscompares++;
        $display("FAIL scoreboard: got idx=%0d oh=%b cv=%b lk=%b se=%b ec=%0d expected idx=%0d oh=%b cv=%b lk=%b se=%b ec=%0d at %0t",
                 state_idx, onehot, code_valid, locked, seq_err, err_count,
                 e.idx, e.oh, e.cv, e.lk, e.se, e.ec, $time);
      end
    end
  end

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_idx"}, 32'(state_idx), 0);
    chk({tag, "_oh"}, 32'(onehot), 0);
    chk({tag, "_cv"}, 32'(code_valid), 0);
    chk({tag, "_lk"}, 32'(locked), 0);
    chk({tag, "_se"}, 32'(seq_err), 0);
    chk({tag, "_ec"}, 32'(err_count), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] code;
    int r, ill;
    logic [7:0] ec_sat;
`ifdef JOHNSON_DECODER_ERRCNT_EN
    ec_sat = 8'd255;
`else
    ec_sat = 8'd0;
`endif
    model_reset();
    #12;
    check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // lock acquisition
    apply(1, 4'b0000); apply(1, 4'b0001); apply(1, 4'b0011); apply(1, 4'b0111);
    settle();
    chk("lock_locked", 32'(locked), 1);
    chk("lock_idx", 32'(state_idx), 3);
    chk("lock_oh", 32'(onehot), 32'h08);

    // full locked cycle with wrap, then stop locked at 0011
    apply(1, 4'b1111); apply(1, 4'b1110); apply(1, 4'b1100); apply(1, 4'b1000);
    apply(1, 4'b0000);
    settle();
    chk("wrap_idx", 32'(state_idx), 0);
    chk("wrap_locked", 32'(locked), 1);
    apply(1, 4'b0001); apply(1, 4'b0011);

    // illegal code while locked
    apply(1, 4'b0101);
    settle();
    chk("illegal_se", 32'(seq_err), 1);
    chk("illegal_cv", 32'(code_valid), 0);
    chk("illegal_oh", 32'(onehot), 0);
    chk("illegal_lk", 32'(locked), 0);
    chk("illegal_idx", 32'(state_idx), 2);
`ifdef JOHNSON_DECODER_ERRCNT_EN
    chk("illegal_ec", 32'(err_count), 1);
`else
    chk("illegal_ec", 32'(err_count), 0);
`endif

    // skip while locked at 1110, then relock
    apply(1, 4'b0000); apply(1, 4'b0001); apply(1, 4'b0011); apply(1, 4'b0111);
    apply(1, 4'b1111); apply(1, 4'b1110);
    apply(1, 4'b1000);
    settle();
    chk("skip_se", 32'(seq_err), 1);
    chk("skip_lk", 32'(locked), 0);
    chk("skip_idx", 32'(state_idx), 7);
    apply(1, 4'b0000); apply(1, 4'b0001); apply(1, 4'b0011);
    settle();
    chk("relock", 32'(locked), 1);

    // repeated code while locked
    apply(1, 4'b0011);

    // valid low with illegal toggling
    apply(1, 4'b0111);
    for (int i = 0; i < 5; i++) apply(0, (i % 2) ? 4'b1010 : 4'b0101);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      code = 4'(jc((m_idx + 1) % N));
      else if (r < 7) code = 4'(jc(m_idx));
      else if (r < 8) code = 4'(jc($urandom_range(0, N - 1)));
      else            code = 4'($urandom_range(0, 15));
      apply($urandom_range(0, 4) != 0, code);
    end

    // saturation with 300 illegal codes
    for (int i = 0; i < 300; i++) begin
      do ill = $urandom_range(0, 15); while (code_index(ill) >= 0);
      apply(1, 4'(ill));
    end
    settle();
    chk("sat_ec", 32'(err_count), 32'(ec_sat));

    // asynchronous reset while locked
    apply(1, 4'b0000); apply(1, 4'b0001); apply(1, 4'b0011); apply(1, 4'b0111);
    apply(1, 4'b1111);
    @(posedge clk);
    #3;
    chk("pre_reset_lk", 32'(locked), 1);
    reset_n = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    apply(1, 4'b0011); apply(1, 4'b0111); apply(1, 4'b1111);
    settle();
    chk("post_reset_unlocked", 32'(locked), 0);
    apply(1, 4'b1110);
    settle();
    chk("post_reset_relock", 32'(locked), 1);

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drain", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/johnson_decoder.md
JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the Johnson code width; the sequence length is N = 2*WIDTH states.
REQ-002 Parameter LOCK_CNT, default 3, SHALL set the number of consecutive legal advances required to declare lock (range 1..15).
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on the rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 q_in  input  WIDTH  SHALL be the Johnson code sampled from the counter under observation.
REQ-006 valid_in  input  1  SHALL qualify q_in; q_in is sampled only when high.
REQ-007 state_idx  output  clog2(N)  SHALL be the decoded index of the last sampled legal code.
REQ-008 onehot  output  N  SHALL be the one-hot form of state_idx; it is all-zero when code_valid is low.
REQ-009 code_valid  output  1  SHALL indicate that the last sampled code was a legal Johnson code.
REQ-010 locked  output  1  SHALL indicate that the decoder is tracking a legal sequence.
REQ-011 seq_err  output  1  SHALL be a one-cycle pulse flagging an illegal code or an out-of-sequence advance.
REQ-012 err_count  output  8  SHALL be a saturating count of seq_err pulses.

Function
REQ-013 Legal code k SHALL be defined as follows, with the zero code mapping to index 0:
  - for 0<=k<=WIDTH: the low k bits are 1 and all other bits are 0;
  - for WIDTH<k<N: the high N-k bits are 1 and all other bits are 0.
  - Example for WIDTH=4: 0000=0, 0001=1, 0011=2, 0111=3, 1111=4, 1110=5, 1100=6, 1000=7.
REQ-014 All outputs SHALL be registered, with a latency of exactly 1 cycle from the valid_in sample to the output update.
REQ-015 When valid_in is low, state_idx, onehot, code_valid, locked and err_count SHALL hold their values, and seq_err SHALL be 0.
REQ-016 On an illegal code, the decoder SHALL:
  - drive code_valid=0 and onehot=0;
  - hold state_idx;
  - pulse seq_err;
  - go to UNLOCKED.
REQ-017 The FSM SHALL have the states UNLOCKED, ACQUIRE and LOCKED, and locked SHALL be 1 only in LOCKED.
REQ-018 UNLOCKED SHALL move to ACQUIRE on any legal code, loading that code as the reference and clearing the advance counter to 0.
REQ-019 In ACQUIRE, the decoder SHALL behave as follows:
  - a legal code equal to (ref+1) mod N increments the advance counter and becomes the new ref;
  - reaching LOCK_CNT moves the FSM to LOCKED;
  - any other legal code reloads ref, clears the counter and asserts no seq_err.
REQ-020 In LOCKED, a legal code that is not (ref+1) mod N SHALL pulse seq_err and move the FSM to ACQUIRE using that code as the new ref.
REQ-021 The wrap from index N-1 to index 0 SHALL count as a legal advance.
REQ-022 A repeated code (the counter stalled) SHALL be treated as out-of-sequence.
REQ-023 err_count SHALL saturate at 255 and SHALL NOT wrap.

Reset
REQ-024 Asserting reset_n low SHALL, immediately and without waiting for clk, set:
  - state_idx=0, onehot=0, code_valid=0;
  - locked=0, seq_err=0, err_count=0;
  - FSM=UNLOCKED, ref=0, advance counter=0.
REQ-025 A reset asserted mid-lock SHALL discard all tracking.
REQ-026 The first valid sample after reset release SHALL be handled as in UNLOCKED.

Configuration
REQ-027 With JOHNSON_DECODER_ERRCNT_EN defined, err_count SHALL behave as in REQ-012 and REQ-023.
REQ-028 Without JOHNSON_DECODER_ERRCNT_EN, err_count SHALL be tied to 0 and no counter logic SHALL be instantiated, while seq_err SHALL remain functional.

Verification
REQ-029 Reset, release, then the sequence 0000,0001,0011,0111 with valid_in high -> locked=1 one cycle after the 0111 sample, with state_idx=3 and onehot=8'b0000_1000.
REQ-030 A locked full cycle 0000..1000 followed by 0000 -> state_idx wraps 7->0, locked stays 1, and seq_err never pulses.
REQ-031 While locked at 0011, apply 0101 -> a one-cycle seq_err pulse, code_valid=0, onehot=0, locked=0, state_idx held at 2, err_count=1.
REQ-032 While locked at 1110, apply 1000 (a skip) -> seq_err pulses, locked=0, state_idx=7, and three further legal advances relock.
REQ-033 With valid_in low for 5 cycles while q_in toggles illegally -> no output changes.
REQ-034 Inject 300 illegal codes with the macro defined -> err_count=255; without the macro -> err_count=0; in both builds, assert reset_n mid-stream -> all outputs 0 asynchronously.
